// File: rtl/fpu_ctrl_pkg.sv
// Shared types and constants for the fpu request arbiter.
// Holds the controller state encoding and the opcode definitions.
package fpu_ctrl_pkg;

    localparam int OP_W = 3;
    localparam logic [OP_W-1:0] OP_IDLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } fpu_state_e;

    function automatic logic is_idle_op(input logic [OP_W-1:0] op);
        return (op == OP_IDLE);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: searches from last_grant+1 upward (wrapping)
// and reports the first active request as a one-hot grant and an index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    index
);

    logic          found_s;
    logic [IW-1:0] cand_s;

    // Rotating priority search over all requesters
    always_comb begin
        grant   = '0;
        index   = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand_s = IW'((int'(last_grant) + i) % N_REQ);
            if (!found_s && req[cand_s]) begin
                found_s       = 1'b1;
                grant[cand_s] = 1'b1;
                index         = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one fpu among N_REQ requesters: round-robin grant, single
// operation in flight, wait timeout with error response.
module fpu_arbiter
    import fpu_ctrl_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ*OP_W-1:0]        req_op,
    input  logic [N_REQ*DATA_WIDTH-1:0]  req_a,
    input  logic [N_REQ*DATA_WIDTH-1:0]  req_b,
    output logic [N_REQ-1:0]             resp_valid,
    input  logic [N_REQ-1:0]             resp_ready,
    output logic [DATA_WIDTH-1:0]        resp_result,
    output logic                         resp_err,
    output logic                         fpu_start,
    output logic [OP_W-1:0]              fpu_op,
    output logic [DATA_WIDTH-1:0]        fpu_a,
    output logic [DATA_WIDTH-1:0]        fpu_b,
    input  logic [DATA_WIDTH-1:0]        fpu_result,
    input  logic                         fpu_rdy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    fpu_state_e            state_r;
    fpu_state_e            next_state_s;
    logic [IW-1:0]         last_grant_r;
    logic [IW-1:0]         id_r;
    logic [IW-1:0]         win_idx_s;
    logic [N_REQ-1:0]      win_grant_s;
    logic [OP_W-1:0]       op_r;
    logic [DATA_WIDTH-1:0] a_r;
    logic [DATA_WIDTH-1:0] b_r;
    logic [DATA_WIDTH-1:0] result_r;
    logic                  err_r;
    logic [CW-1:0]         wait_cnt_r;
    logic                  timeout_hit_s;
    logic [N_REQ-1:0]      id_onehot_s;

    logic [OP_W-1:0]       op_arr_s [N_REQ];
    logic [DATA_WIDTH-1:0] a_arr_s  [N_REQ];
    logic [DATA_WIDTH-1:0] b_arr_s  [N_REQ];

    genvar g;
    generate
        for (g = 0; g < N_REQ; g++) begin : g_unpack
            assign op_arr_s[g] = req_op[g*OP_W +: OP_W];
            assign a_arr_s[g]  = req_a[g*DATA_WIDTH +: DATA_WIDTH];
            assign b_arr_s[g]  = req_b[g*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .grant      (win_grant_s),
        .index      (win_idx_s)
    );

    // Expires on the last of TIMEOUT wait cycles, so the counter never exceeds TIMEOUT
    assign timeout_hit_s = (wait_cnt_r + CW'(1)) == CW'(TIMEOUT);
    assign id_onehot_s   = {{(N_REQ-1){1'b0}}, 1'b1} << id_r;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (|req_valid) begin
                    next_state_s = is_idle_op(op_arr_s[win_idx_s]) ? ST_RESP : ST_ISSUE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: next_state_s = ST_WAIT;
            ST_WAIT: begin
                if (fpu_rdy || timeout_hit_s) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (resp_ready[id_r]) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Operation capture, grant history, wait counter and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_r <= IW'(N_REQ - 1);
            id_r         <= '0;
            op_r         <= '0;
            a_r          <= '0;
            b_r          <= '0;
            result_r     <= '0;
            err_r        <= 1'b0;
            wait_cnt_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|req_valid) begin
                        id_r         <= win_idx_s;
                        last_grant_r <= win_idx_s;
                        op_r         <= op_arr_s[win_idx_s];
                        a_r          <= a_arr_s[win_idx_s];
                        b_r          <= b_arr_s[win_idx_s];
                        result_r     <= '0;
                        err_r        <= 1'b0;
                    end
                end
                ST_ISSUE: wait_cnt_r <= '0;
                ST_WAIT: begin
                    wait_cnt_r <= wait_cnt_r + CW'(1);
                    if (fpu_rdy) begin
                        result_r <= fpu_result;
                        err_r    <= 1'b0;
                    end else if (timeout_hit_s) begin
                        result_r <= '0;
                        err_r    <= 1'b1;
                    end
                end
                ST_RESP: ;
                default: ;
            endcase
        end
    end

    // Output decode from the registered state
    always_comb begin
        req_ready   = '0;
        resp_valid  = '0;
        resp_result = '0;
        resp_err    = 1'b0;
        fpu_start   = 1'b0;
        fpu_op      = '0;
        fpu_a       = '0;
        fpu_b       = '0;
        case (state_r)
            ST_IDLE: begin
                if (!reset) begin
                    req_ready = win_grant_s;
                end else begin
                    req_ready = '0;
                end
            end
            ST_ISSUE: begin
                fpu_start = 1'b1;
                fpu_op    = op_r;
                fpu_a     = a_r;
                fpu_b     = b_r;
            end
            ST_WAIT: begin
                fpu_op = op_r;
                fpu_a  = a_r;
                fpu_b  = b_r;
            end
            ST_RESP: begin
                resp_valid  = id_onehot_s;
                resp_result = result_r;
                resp_err    = err_r;
            end
            default: req_ready = '0;
        endcase
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboard bench for fpu_arbiter with a behavioural fpu that answers
// FPU_LAT cycles after each start pulse (or never, when stalled).
module tb_fpu_arbiter;

    localparam int N       = 4;
    localparam int DW      = 32;
    localparam int TO      = 64;
    localparam int FPU_LAT = 30;

    typedef struct {
        int            id;
        logic [DW-1:0] res;
        logic          err;
        int            acc;
        int            lat;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*3-1:0]  req_op = '0;
    logic [N*DW-1:0] req_a = '0;
    logic [N*DW-1:0] req_b = '0;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready = '0;
    logic [DW-1:0]   resp_result;
    logic            resp_err;
    logic            fpu_start;
    logic [2:0]      fpu_op;
    logic [DW-1:0]   fpu_a;
    logic [DW-1:0]   fpu_b;
    logic [DW-1:0]   fpu_result;
    logic            fpu_rdy;

    int   tests_run = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t sb[$];

    logic          model_rdy = 1'b0;
    logic [DW-1:0] model_res = '0;
    logic          stray_rdy = 1'b0;
    logic [DW-1:0] stray_res = '0;
    logic          stall = 1'b0;
    logic          pend = 1'b0;
    int            st_cyc = 0;
    int            start_count = 0;
    logic [2:0]    m_op = '0;
    logic [DW-1:0] m_a = '0;
    logic [DW-1:0] m_b = '0;

    fpu_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_err    (resp_err),
        .fpu_start   (fpu_start),
        .fpu_op      (fpu_op),
        .fpu_a       (fpu_a),
        .fpu_b       (fpu_b),
        .fpu_result  (fpu_result),
        .fpu_rdy     (fpu_rdy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [DW-1:0] fpu_func(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (op == 3'b001) return a + b;
        else if (op == 3'b010) return a - b;
        else return a ^ b;
    endfunction

    // Behavioural fpu: one result strobe FPU_LAT cycles after the start pulse
    always @(posedge clock) begin
        model_rdy <= 1'b0;
        if (reset) begin
            pend <= 1'b0;
        end else if (fpu_start) begin
            pend        <= 1'b1;
            st_cyc      <= cyc;
            m_op        <= fpu_op;
            m_a         <= fpu_a;
            m_b         <= fpu_b;
            start_count <= start_count + 1;
        end else if (pend && (cyc + 1 == st_cyc + FPU_LAT)) begin
            pend      <= 1'b0;
            model_rdy <= !stall;
            model_res <= fpu_func(m_op, m_a, m_b);
        end
    end

    assign fpu_rdy    = model_rdy | stray_rdy;
    assign fpu_result = stray_rdy ? stray_res : model_res;

    task automatic set_req(input int id, input logic v, input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_valid[id]         = v;
        req_op[id*3 +: 3]     = op;
        req_a[id*DW +: DW]    = a;
        req_b[id*DW +: DW]    = b;
    endtask

    // Waits for a grant to requester id and pushes the expected response
    task automatic accept(input int id, input logic [N-1:0] exp_ready, input logic [DW-1:0] res, input logic err, input int lat);
        bit   got = 1'b0;
        exp_t e;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clock);
            if (req_ready[id]) got = 1'b1;
        end
        tests_run++;
        if (req_ready !== exp_ready) begin
            fails++;
            $display("FAIL grant_%0d: req_ready=%b expected %b", id, req_ready, exp_ready);
        end
        e.id = id; e.res = res; e.err = err; e.acc = cyc; e.lat = lat;
        sb.push_back(e);
        @(posedge clock); #1;
        set_req(id, 1'b0, 3'b000, '0, '0);
    endtask

    // Waits for the pending response and compares it with the scoreboard head
    task automatic check_resp(input string name, input int budget);
        bit            got = 1'b0;
        exp_t          e;
        logic [N-1:0]  oh;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clock);
            if (|resp_valid) got = 1'b1;
        end
        tests_run++;
        if (!got || sb.size() == 0) begin
            fails++;
            $display("FAIL %s: no response within %0d cycles (pending=%0d)", name, budget, sb.size());
        end else begin
            e  = sb.pop_front();
            oh = 4'b0001 << e.id;
            if (resp_valid !== oh || resp_result !== e.res || resp_err !== e.err || (cyc - e.acc) != e.lat) begin
                fails++;
                $display("FAIL %s: valid=%b res=%h err=%b lat=%0d expected valid=%b res=%h err=%b lat=%0d",
                         name, resp_valid, resp_result, resp_err, cyc - e.acc, oh, e.res, e.err, e.lat);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        tests_run++;
        if ({req_ready, resp_valid, resp_err, fpu_start, fpu_op} !== '0 || resp_result !== '0 || fpu_a !== '0 || fpu_b !== '0) begin
            fails++;
            $display("FAIL reset_outputs: rr=%b rv=%b err=%b st=%b op=%b res=%h a=%h b=%h expected all zero",
                     req_ready, resp_valid, resp_err, fpu_start, fpu_op, resp_result, fpu_a, fpu_b);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({req_ready, resp_valid, resp_err, fpu_start, fpu_op} !== '0 || resp_result !== '0) begin
            fails++;
            $display("FAIL idle_outputs: rr=%b rv=%b err=%b st=%b op=%b res=%h expected all zero",
                     req_ready, resp_valid, resp_err, fpu_start, fpu_op, resp_result);
        end
    endtask

    task automatic test_single();
        resp_ready = '1;
        @(posedge clock); #1;
        set_req(0, 1'b1, 3'b001, 32'd5, 32'd7);
        accept(0, 4'b0001, 32'd12, 1'b0, 32);
        @(negedge clock);
        tests_run++;
        if (fpu_start !== 1'b1 || fpu_op !== 3'b001 || fpu_a !== 32'd5 || fpu_b !== 32'd7) begin
            fails++;
            $display("FAIL issue: start=%b op=%b a=%h b=%h expected 1 001 5 7", fpu_start, fpu_op, fpu_a, fpu_b);
        end
        @(negedge clock);
        tests_run++;
        if (fpu_start !== 1'b0 || fpu_a !== 32'd5 || fpu_b !== 32'd7) begin
            fails++;
            $display("FAIL wait_hold: start=%b a=%h b=%h expected 0 5 7", fpu_start, fpu_a, fpu_b);
        end
        check_resp("single_resp", 100);
        @(negedge clock);
        tests_run++;
        if (resp_valid !== 4'b0000 || fpu_a !== 32'd0 || fpu_op !== 3'b000) begin
            fails++;
            $display("FAIL single_done: rv=%b a=%h op=%b expected 0 0 0", resp_valid, fpu_a, fpu_op);
        end
    endtask

    task automatic test_fairness();
        int   order[$];
        int   exp_order[5] = '{0, 1, 2, 3, 0};
        int   nresp = 0;
        int   idx;
        exp_t e;
        logic [N-1:0] oh;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        resp_ready = '1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'b001, 32'(i * 16 + 3), 32'(i + 100));
        for (int k = 0; k < 600 && nresp < 5; k++) begin
            @(negedge clock);
            if (|req_ready) begin
                idx = 0;
                for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
                order.push_back(idx);
                e.id = idx; e.res = 32'(idx * 16 + 3) + 32'(idx + 100); e.err = 1'b0; e.acc = cyc; e.lat = 32;
                sb.push_back(e);
            end
            if (|resp_valid && sb.size() > 0) begin
                e  = sb.pop_front();
                oh = 4'b0001 << e.id;
                nresp++;
                tests_run++;
                if (resp_valid !== oh || resp_result !== e.res || resp_err !== 1'b0 || (cyc - e.acc) != 32) begin
                    fails++;
                    $display("FAIL fair_resp_%0d: valid=%b res=%h lat=%0d expected %b %h 32",
                             nresp, resp_valid, resp_result, cyc - e.acc, oh, e.res);
                end
            end
            @(posedge clock); #1;
            if (order.size() >= 5) req_valid = '0;
        end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (i >= order.size() || order[i] != exp_order[i]) begin
                fails++;
                $display("FAIL fair_order_%0d: got %0d expected %0d", i, (i < order.size()) ? order[i] : -1, exp_order[i]);
            end
        end
    endtask

    task automatic test_idle_op();
        int sc;
        resp_ready = '1;
        @(posedge clock); #1;
        sc = start_count;
        set_req(2, 1'b1, 3'b000, 32'h0000_AAAA, 32'h0000_5555);
        accept(2, 4'b0100, 32'd0, 1'b0, 1);
        check_resp("idle_op_resp", 3);
        repeat (3) @(posedge clock);
        @(negedge clock);
        tests_run++;
        if (start_count != sc) begin
            fails++;
            $display("FAIL idle_op_nostart: starts=%0d expected %0d", start_count, sc);
        end
    endtask

    task automatic test_timeout();
        stall      = 1'b1;
        resp_ready = 4'b0111;
        @(posedge clock); #1;
        set_req(3, 1'b1, 3'b001, 32'd1, 32'd2);
        accept(3, 4'b1000, 32'd0, 1'b1, TO + 2);
        check_resp("timeout_resp", 200);
        @(posedge clock); #1;
        stray_rdy = 1'b1;
        stray_res = 32'hDEAD_BEEF;
        @(posedge clock); #1;
        stray_rdy = 1'b0;
        @(negedge clock);
        tests_run++;
        if (resp_valid !== 4'b1000 || resp_result !== 32'd0 || resp_err !== 1'b1) begin
            fails++;
            $display("FAIL stray_rdy: rv=%b res=%h err=%b expected 1000 0 1", resp_valid, resp_result, resp_err);
        end
        resp_ready[3] = 1'b1;
        @(posedge clock); #1;
        stray_rdy = 1'b1;
        @(posedge clock); #1;
        stray_rdy = 1'b0;
        @(negedge clock);
        tests_run++;
        if (resp_valid !== 4'b0000 || fpu_start !== 1'b0) begin
            fails++;
            $display("FAIL stray_idle: rv=%b start=%b expected 0000 0", resp_valid, fpu_start);
        end
        stall = 1'b0;
    endtask

    task automatic test_backpressure();
        resp_ready = 4'b1101;
        @(posedge clock); #1;
        set_req(1, 1'b1, 3'b010, 32'd100, 32'd30);
        accept(1, 4'b0010, 32'd70, 1'b0, 32);
        check_resp("bp_resp", 100);
        set_req(0, 1'b1, 3'b001, 32'd9, 32'd9);
        for (int k = 0; k < 10; k++) begin
            @(posedge clock); #1;
            @(negedge clock);
            tests_run++;
            if (resp_valid !== 4'b0010 || resp_result !== 32'd70 || resp_err !== 1'b0 || req_ready !== 4'b0000) begin
                fails++;
                $display("FAIL bp_hold_%0d: rv=%b res=%h err=%b rr=%b expected 0010 46 0 0000",
                         k, resp_valid, resp_result, resp_err, req_ready);
            end
        end
        @(posedge clock); #1;
        resp_ready[1] = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        tests_run++;
        if (resp_valid !== 4'b0000 || req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL bp_release: rv=%b rr=%b expected 0000 0001", resp_valid, req_ready);
        end
        @(posedge clock); #1;
        set_req(0, 1'b0, 3'b000, '0, '0);
    endtask

    task automatic test_reset_wait();
        int seen = 0;
        repeat (5) @(posedge clock);
        #1;
        @(negedge clock);
        tests_run++;
        if (fpu_op !== 3'b001 || fpu_a !== 32'd9 || fpu_start !== 1'b0) begin
            fails++;
            $display("FAIL in_wait: op=%b a=%h start=%b expected 001 9 0", fpu_op, fpu_a, fpu_start);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        tests_run++;
        if ({req_ready, resp_valid, resp_err, fpu_start, fpu_op} !== '0 || fpu_a !== '0 || fpu_b !== '0 || resp_result !== '0) begin
            fails++;
            $display("FAIL reset_wait_outputs: rr=%b rv=%b st=%b op=%b a=%h expected all zero",
                     req_ready, resp_valid, fpu_start, fpu_op, fpu_a);
        end
        reset = 1'b0;
        sb.delete();
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (|resp_valid || fpu_start) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            fails++;
            $display("FAIL aborted_no_resp: activity cycles=%0d expected 0", seen);
        end
        @(posedge clock); #1;
        set_req(0, 1'b1, 3'b001, 32'd20, 32'd22);
        set_req(1, 1'b1, 3'b001, 32'd1, 32'd1);
        accept(0, 4'b0001, 32'd42, 1'b0, 32);
        set_req(1, 1'b0, 3'b000, '0, '0);
        check_resp("after_reset_resp", 100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_idle_op();
        test_timeout();
        test_backpressure();
        test_reset_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
